// File: rtl/seq_drain.sv
// Drives the sequence core through start/next for a commanded count and streams the
// returned values through a small FIFO, tagging the final value of each command.
module seq_drain #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic [DATA_W-1:0] cmd_k,
    output logic              EN_start,
    input  logic              RDY_start,
    output logic [DATA_W-1:0] next_k,
    output logic              EN_next,
    input  logic [DATA_W-1:0] next,
    input  logic              RDY_next,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FullCnt = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StRun, StDrain} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] k_q, k_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic [DEPTH-1:0]  mem_last_q;
    logic              push, pop, full;

    assign full      = (cnt_q == FullCnt);
    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign next_k    = k_q;
    assign EN_start  = (state_q == StStart) & RDY_start;
    // Never push when full, even if the head is popped this cycle.
    assign EN_next   = (state_q == StRun) & RDY_next & ~full;
    assign push      = EN_next;
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem_data_q[rd_ptr_q] : '0;
    assign out_last  = out_valid & mem_last_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        rem_d   = rem_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    k_d   = cmd_k;
                    rem_d = cmd_count;
                    if (cmd_count != '0) state_d = StStart;
                end
            end
            StStart: begin
                if (RDY_start) state_d = StRun;
            end
            StRun: begin
                if (push) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) state_d = StDrain;
                end
            end
            StDrain: begin
                // Leave as the last entry pops so cmd_ready rises the following cycle.
                if (cnt_d == '0) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= StIdle;
            k_q      <= '0;
            rem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            rem_q    <= rem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= next;
            mem_last_q[wr_ptr_q] <= (rem_q == CNT_W'(1));
        end
    end

endmodule

// File: tb/tb_seq_drain.sv
// Directed bench for seq_drain: a counting core model feeds next values, a monitor logs
// method firings and stream pops, and cycle-exact checks compare against hand-derived values.
module tb_seq_drain;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        cmd_valid, cmd_ready;
    logic [15:0] cmd_count;
    logic [31:0] cmd_k;
    logic        EN_start, RDY_start;
    logic [31:0] next_k;
    logic        EN_next, RDY_next;
    logic [31:0] next;
    logic        out_valid, out_ready, out_last, busy;
    logic [31:0] out_data;

    int          vectors = 0;
    int          miscompares = 0;
    int          start_n = 0, next_n = 0, pop_n = 0, viol_n = 0;
    logic [31:0] pop_data [64];
    logic        pop_last [64];
    logic [31:0] next_off = '0;
    int          s0, n0, p0;

    // Core model: the i-th next call returns next_off + i.
    assign next = next_off + 32'(next_n);

    always #5 CLK = ~CLK;

    seq_drain dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_count(cmd_count),
        .cmd_k    (cmd_k),
        .EN_start (EN_start),
        .RDY_start(RDY_start),
        .next_k   (next_k),
        .EN_next  (EN_next),
        .next     (next),
        .RDY_next (RDY_next),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy)
    );

    always @(posedge CLK) begin
        if (EN_start) start_n <= start_n + 1;
        if (EN_next)  next_n  <= next_n + 1;
        if ((EN_start && !RDY_start) || (EN_next && !RDY_next)) viol_n <= viol_n + 1;
        if (out_valid && out_ready && pop_n < 64) begin
            pop_data[pop_n] <= out_data;
            pop_last[pop_n] <= out_last;
            pop_n           <= pop_n + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic mark(input logic [31:0] base);
        s0 = start_n;
        n0 = next_n;
        p0 = pop_n;
        next_off = base - 32'(next_n);
    endtask

    task automatic check_pops(input string tag, input int n, input logic [31:0] base,
                              input int last_at);
        check({tag, "_npop"}, 64'(pop_n - p0), 64'(n));
        for (int i = 0; i < n; i++) begin
            check({tag, "_data"}, 64'(pop_data[p0+i]), 64'(base + 32'(i)));
            check({tag, "_last"}, 64'(pop_last[p0+i]), 64'((i == last_at) || (i == n - 1)));
        end
    endtask

    task automatic send_cmd(input logic [15:0] cnt, input logic [31:0] k);
        cmd_valid = 1'b1;
        cmd_count = cnt;
        cmd_k     = k;
        #1;
        check("cmd_accept", 64'(cmd_ready), 64'd1);
        cyc();
        cmd_valid = 1'b0;
        #1;
    endtask

    initial begin
        RST_N = 1'b0;
        cmd_valid = 1'b0; cmd_count = '0; cmd_k = '0;
        RDY_start = 1'b1; RDY_next = 1'b1; out_ready = 1'b1;
        #12;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_en_start", 64'(EN_start), 64'd0);
        check("rst_en_next", 64'(EN_next), 64'd0);
        check("rst_next_k", 64'(next_k), 64'd0);
        check("rst_out", 64'({out_valid, out_last, out_data}), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        RST_N = 1'b1;
        cyc();

        // Basic run
        mark(32'd10);
        send_cmd(16'd3, 32'd5);
        check("b_start", 64'(EN_start), 64'd1);
        check("b_next0", 64'(EN_next), 64'd0);
        cyc();
        check("b_next1", 64'({EN_next, out_valid}), 64'b10);
        check("b_k", 64'(next_k), 64'd5);
        cyc();
        check("b_next2", 64'(EN_next), 64'd1);
        check("b_out0", 64'({out_valid, out_last, out_data}), {31'd0, 2'b10, 32'd10});
        cyc();
        check("b_next3", 64'(EN_next), 64'd1);
        check("b_out1", 64'({out_valid, out_last, out_data}), {31'd0, 2'b10, 32'd11});
        cyc();
        check("b_next_off", 64'(EN_next), 64'd0);
        check("b_out2", 64'({out_valid, out_last, out_data}), {31'd0, 2'b11, 32'd12});
        check("b_rdy_drain", 64'(cmd_ready), 64'd0);
        cyc();
        check("b_rdy_back", 64'({cmd_ready, busy, out_valid}), 64'b100);
        check("b_nstart", 64'(start_n - s0), 64'd1);
        check("b_nnext", 64'(next_n - n0), 64'd3);
        check_pops("b", 3, 32'd10, 2);

        // Backpressure
        mark(32'd20);
        out_ready = 1'b0;
        send_cmd(16'd6, 32'd6);
        repeat (9) cyc();
        check("bp_nnext4", 64'(next_n - n0), 64'd4);
        check("bp_hold", 64'({EN_next, out_valid, out_data}), {31'd0, 2'b01, 32'd20});
        cyc();
        check("bp_stable", 64'({out_valid, out_last, out_data}), {31'd0, 2'b10, 32'd20});
        out_ready = 1'b1;
        repeat (20) cyc();
        check("bp_nnext6", 64'(next_n - n0), 64'd6);
        check("bp_idle", 64'(cmd_ready), 64'd1);
        check_pops("bp", 6, 32'd20, 5);

        // Zero count
        mark(32'd30);
        send_cmd(16'd0, 32'd9);
        check("z_ctl", 64'({cmd_ready, busy, EN_start, EN_next}), 64'b1000);
        repeat (3) cyc();
        check("z_nact", 64'((start_n - s0) + (next_n - n0)), 64'd0);
        check("z_k", 64'(next_k), 64'd9);

        // Core stalls
        mark(32'd40);
        RDY_start = 1'b0; RDY_next = 1'b0;
        send_cmd(16'd2, 32'd3);
        check("s_st0", 64'(EN_start), 64'd0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("s_stl", 64'(EN_start), 64'd0);
        end
        cyc(); RDY_start = 1'b1; #1;
        check("s_st1", 64'(EN_start), 64'd1);
        cyc(); RDY_start = 1'b0; RDY_next = 1'b1; #1;
        check("s_n1", 64'({EN_start, EN_next}), 64'b01);
        check("s_k", 64'(next_k), 64'd3);
        cyc(); RDY_next = 1'b0; #1;
        check("s_n0", 64'(EN_next), 64'd0);
        cyc(); RDY_next = 1'b1; #1;
        check("s_n1b", 64'(EN_next), 64'd1);
        cyc(); RDY_next = 1'b0; #1;
        check("s_n0b", 64'(EN_next), 64'd0);
        RDY_start = 1'b1; RDY_next = 1'b1;
        repeat (5) cyc();
        check("s_counts", 64'({32'(start_n - s0), 32'(next_n - n0)}), {32'd1, 32'd2});
        check_pops("s", 2, 32'd40, 1);

        // Command held during run
        mark(32'd50);
        cmd_valid = 1'b1; cmd_count = 16'd3; cmd_k = 32'd7; #1;
        cyc();
        cmd_count = 16'd2; cmd_k = 32'd8; #1;
        for (int i = 0; i < 4; i++) begin
            check("h_busy_rdy", 64'(cmd_ready), 64'd0);
            check("h_k", 64'(next_k), 64'd7);
            cyc();
        end
        check("h_drain_rdy", 64'(cmd_ready), 64'd0);
        cyc();
        check("h_idle_rdy", 64'({cmd_ready, next_k}), {31'd0, 1'b1, 32'd7});
        cyc();
        cmd_valid = 1'b0; #1;
        check("h_k2", 64'({EN_start, next_k}), {31'd0, 1'b1, 32'd8});
        repeat (8) cyc();
        check("h_nnext", 64'(next_n - n0), 64'd5);
        check_pops("h", 5, 32'd50, 2);

        // Reset mid-run
        mark(32'd60);
        out_ready = 1'b0;
        send_cmd(16'd5, 32'd4);
        repeat (3) cyc();
        check("r_pre", 64'({out_valid, out_data}), {31'd0, 1'b1, 32'd60});
        check("r_pre_n", 64'(next_n - n0), 64'd2);
        RST_N = 1'b0; #1;
        check("r_async", 64'({out_valid, EN_next, cmd_ready, busy}), 64'b0010);
        check("r_k", 64'(next_k), 64'd0);
        cyc();
        check("r_hold", 64'({EN_start, EN_next, out_valid}), 64'b000);
        RST_N = 1'b1;
        out_ready = 1'b1;
        cyc();
        mark(32'd70);
        send_cmd(16'd1, 32'd2);
        repeat (6) cyc();
        check("r_new", 64'({32'(start_n - s0), 32'(next_n - n0)}), {32'd1, 32'd1});
        check("r_idle", 64'(cmd_ready), 64'd1);
        check_pops("r", 1, 32'd70, 0);

        check("method_rule", 64'(viol_n), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
